uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  8N1 UART receiver: oversamples serial line RX with the system clock, detects the start
//  bit, samples each bit at its centre, deserialises LSB-first into a byte.
//  Presents the byte on Received_DATA with a one-cycle Done strobe.
//  Internally: control FSM, half-bit counter, full-bit counter, bit/frame counter,
//  serial-in/parallel-out shift register. Sits behind the pin, feeding the host/command logic.
// PARAMETERS
//  CLKS_PER_BIT  439  clock cycles per UART bit (bit time / clk period); must be >= 4
//  DATA_WIDTH    8    data bits per frame (word_lenght_t width)
//  HALF_BIT      CLKS_PER_BIT/2 (derived, floor; 219 at default) - start-bit centring delay
// PORTS
//  clk            in   1           system clock, all logic on rising edge
//  rst            in   1           asynchronous, active-low reset
//  RX             in   1           serial input, idle high, asynchronous to clk
//  Done           out  1           one-cycle pulse: valid frame received, Received_DATA updated
//  Received_DATA  out  DATA_WIDTH  last valid received byte (bit0 = first data bit on line)
// BEHAVIOUR
//  Reset (rst=0, async):
//  - FSM->IDLE, all counters 0, shift reg 0, Received_DATA=0, Done=0, sync flops=1.
//  Input sync: RX through 2-FF synchroniser (rx_s); all decisions use rx_s (2-cycle latency).
//  FSM states:
//  - IDLE:  counters cleared. rx_s==0 -> START.
//  - START: half-bit counter runs; on count HALF_BIT-1 (ovf):
//    - rx_s==0 -> DATA, clear shift reg and bit counter;
//    - rx_s==1 -> IDLE (glitch rejected, no Done).
//  - DATA:  full-bit counter counts 0..CLKS_PER_BIT-1, wraps. On each ovf: shift rx_s in at
//           MSB, shift right (LSB-first line order lands bit0 in [0] after 8 shifts); bit
//           counter++. After DATA_WIDTH-th ovf -> STOP.
//  - STOP:  full-bit counter runs one more bit period; on ovf sample rx_s:
//    - 1 -> Received_DATA<=shift reg, Done=1 for exactly that next cycle, -> IDLE;
//    - 0 (framing error) -> discard byte, no Done, Received_DATA unchanged -> IDLE.
//      Re-arms only after rx_s seen high (new falling edge needed).
//  Timing:
//  - Data bit k sampled HALF_BIT + (k+1)*CLKS_PER_BIT cycles after START entry.
//  - Stop bit sampled at HALF_BIT + 9*CLKS_PER_BIT; Done on following cycle.
//  - Done asserts ~2+HALF_BIT+9*CLKS_PER_BIT+1 cycles after RX falling edge.
//  Received_DATA held stable between frames; changes only in the Done cycle.
//  Back-to-back frames: IDLE re-entered right after stop sample, so a start edge 0.5 bit
//  after stop centre is caught.
//  RX activity during DATA/STOP only affects sampling at ovf points; no resync mid-frame.
//  Counters never free-run in IDLE; all counters clear on return to IDLE.
//  Reset mid-frame: immediate abort, outputs to reset values, partial byte lost.
// TESTING
//  1 Reset: rst low 100 cycles, RX=1 -> Done=0, Received_DATA=0x00, no Done for 1000 cycles
//    idle.
//  2 Frame 0x55: start, bits 1,0,1,0,1,0,1,0, stop=1, each 439 clks -> single Done pulse,
//    Received_DATA=0x55.
//  3 Back-to-back: 0x55 then 0xA3 with 50-cycle idle gap -> two Done pulses, values 0x55
//    then 0xA3.
//  4 Glitch: RX low 100 cycles then high -> no Done, FSM back to IDLE, next 0x3C frame
//    received correctly.
//  5 Framing error: frame 0xF0 with stop bit 0 -> no Done, Received_DATA keeps prior value.
//  6 Reset mid-frame: rst pulsed low during bit 4 -> Received_DATA=0, Done=0, next frame
//    0x81 received OK.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronised RX, start-bit centring, LSB-first deserialiser.
// Emits a one-cycle Done strobe with the byte on Received_DATA; framing errors are dropped.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 439,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Received_DATA
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CW-1:0]         half_cnt_q, half_cnt_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         frame_cnt_q, frame_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  armed_q, armed_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            half_cnt_q  <= '0;
            clk_cnt_q   <= '0;
            frame_cnt_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            clk_cnt_q   <= clk_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            done_q      <= done_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        half_cnt_d  = half_cnt_q;
        clk_cnt_d   = clk_cnt_q;
        frame_cnt_d = frame_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        done_d      = 1'b0;
        // After a framing error the line must go high again before a new start is accepted.
        armed_d     = armed_q | rx_s_q;

        unique case (state_q)
            S_IDLE: begin
                half_cnt_d  = '0;
                clk_cnt_d   = '0;
                frame_cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d     = S_DATA;
                        shift_d     = '0;
                        frame_cnt_d = '0;
                        clk_cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d   = '0;
                    shift_d     = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    frame_cnt_d = frame_cnt_q + BW'(1);
                    if (frame_cnt_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    if (rx_s_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        armed_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Done          = done_q;
    assign Received_DATA = data_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected bytes, a monitor pops on Done.
module tb_uart_rx_core;

    localparam int CPB = 439;

    logic       clk;
    logic       rst;
    logic       RX;
    logic       Done;
    logic [7:0] Received_DATA;

    int errors = 0;
    int checks = 0;
    int done_count = 0;
    logic prev_done = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .RX            (RX),
        .Done          (Done),
        .Received_DATA (Received_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expected byte.
    always @(negedge clk) begin
        if (rst) begin
            if (Done) begin
                done_count++;
                check("done_pulse_width", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {24'd0, Received_DATA}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_byte", {24'd0, Received_DATA}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_done = Done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] data, input int nbits);
        RX = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < nbits; i++) begin
            RX = data[i];
            wait_cycles(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        if (stop_bit) exp_q.push_back(data);
        send_bits(data, 8);
        RX = stop_bit;
        wait_cycles(CPB);
        RX = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        RX  = 1'b1;
        wait_cycles(100);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_data", {24'd0, Received_DATA}, 32'h00);
        rst = 1'b1;
        wait_cycles(1000);
        check("idle_no_done", done_count, 0);

        send_frame(8'h55, 1'b1);
        wait_drain("drain_55");
        check("count_after_55", done_count, 1);

        wait_cycles(50);
        send_frame(8'h55, 1'b1);
        wait_cycles(50);
        send_frame(8'hA3, 1'b1);
        wait_drain("drain_b2b");
        check("count_after_b2b", done_count, 3);

        RX = 1'b0;
        wait_cycles(100);
        RX = 1'b1;
        wait_cycles(2 * CPB);
        check("glitch_no_done", done_count, 3);
        check("glitch_data_hold", {24'd0, Received_DATA}, 32'hA3);
        send_frame(8'h3C, 1'b1);
        wait_drain("drain_3c");

        wait_cycles(50);
        send_frame(8'hF0, 1'b0);
        wait_cycles(2 * CPB);
        check("framing_no_done", done_count, 4);
        check("framing_data_hold", {24'd0, Received_DATA}, 32'h3C);

        send_bits(8'h81, 4);
        RX = 1'b0;
        wait_cycles(CPB / 2);
        rst = 1'b0;
        wait_cycles(10);
        check("midreset_done", {31'd0, Done}, 32'd0);
        check("midreset_data", {24'd0, Received_DATA}, 32'h00);
        RX  = 1'b1;
        rst = 1'b1;
        wait_cycles(2 * CPB);
        check("post_reset_data", {24'd0, Received_DATA}, 32'h00);
        check("post_reset_no_done", done_count, 4);

        send_frame(8'h81, 1'b1);
        wait_drain("drain_81");
        wait_cycles(100);
        check("final_done_count", done_count, 5);
        check("final_data", {24'd0, Received_DATA}, 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
